// File: rtl/thermal_governor_pkg.sv
// Shared constants for the thermal governor: register map, CTRL bit
// positions, heater command words and the controller state encoding.
package thermal_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_HIGH   = 2'd1;
    localparam logic [1:0] REG_LOW    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;
    localparam int STATUS_IRQ_CLR_BIT = 30;

    localparam logic [31:0] HEAT_ON  = 32'd1;
    localparam logic [31:0] HEAT_OFF = 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_WRITE   = 3'd5
    } state_t;

    // STATUS layout: heater state, sticky irq, low 30 bits of the last sample.
    function automatic logic [31:0] status_word(input logic heater,
                                                input logic irq_flag,
                                                input logic [29:0] sample);
        return {heater, irq_flag, sample};
    endfunction

endpackage

// File: rtl/thermal_governor_if.sv
// Avalon-MM bundles used by the thermal governor: the host-facing config
// slave (s0) and the HeatSensor-facing master (m0).
interface thermal_avs_if;
    logic [1:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  avs_s0_readdata
    );
    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output avs_s0_readdata
    );
endinterface

interface thermal_avm_if #(parameter int DATA_W = 32);
    logic              avm_m0_read;
    logic              avm_m0_write;
    logic [DATA_W-1:0] avm_m0_writedata;
    logic [DATA_W-1:0] avm_m0_readdata;

    modport master (
        output avm_m0_read, avm_m0_write, avm_m0_writedata,
        input  avm_m0_readdata
    );
    modport slave (
        input  avm_m0_read, avm_m0_write, avm_m0_writedata,
        output avm_m0_readdata
    );
endinterface

// File: rtl/thermal_governor_regs.sv
// Config register file for the thermal governor: CTRL/HIGH/LOW storage,
// registered read-back and the sticky over-temperature interrupt.
// DATA_W must be 30..32 so the STATUS sample field and the 32-bit bus fit.
module thermal_regs
    import thermal_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    thermal_avs_if.slave      avs,
    input  logic              heater_on_i,
    input  logic [DATA_W-1:0] last_sample_i,
    input  logic              irq_set_i,
    output logic              en_o,
    output logic              irq_en_o,
    output logic [DATA_W-1:0] high_o,
    output logic [DATA_W-1:0] low_o,
    output logic              irq_o
);

    logic [1:0]        ctrl_q;
    logic [DATA_W-1:0] high_q;
    logic [DATA_W-1:0] low_q;
    logic              irq_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              wr_ctrl;
    logic              wr_high;
    logic              wr_low;
    logic              irq_clr;

    assign wr_ctrl = avs.avs_s0_write && (avs.avs_s0_address == REG_CTRL);
    assign wr_high = avs.avs_s0_write && (avs.avs_s0_address == REG_HIGH);
    assign wr_low  = avs.avs_s0_write && (avs.avs_s0_address == REG_LOW);
    assign irq_clr = avs.avs_s0_write && (avs.avs_s0_address == REG_STATUS)
                     && avs.avs_s0_writedata[STATUS_IRQ_CLR_BIT];

    // Host writes to the writable registers; HIGH resets to all-ones so the
    // loop never forces the heater off before thresholds are programmed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= 2'b00;
            high_q <= '1;
            low_q  <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= avs.avs_s0_writedata[1:0];
            if (wr_high) high_q <= avs.avs_s0_writedata[DATA_W-1:0];
            if (wr_low)  low_q  <= avs.avs_s0_writedata[DATA_W-1:0];
        end
    end

    // Sticky interrupt; a new set wins over a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (irq_set_i) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    // Read mux; data appears the cycle after the read strobe.
    always_comb begin
        rdata_d = rdata_q;
        if (avs.avs_s0_read) begin
            case (avs.avs_s0_address)
                REG_CTRL: rdata_d = {30'd0, ctrl_q};
                REG_HIGH: rdata_d = 32'(high_q);
                REG_LOW:  rdata_d = 32'(low_q);
                default:  rdata_d = status_word(heater_on_i, irq_q, last_sample_i[29:0]);
            endcase
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign avs.avs_s0_readdata = rdata_q;
    assign en_o     = ctrl_q[CTRL_EN_BIT];
    assign irq_en_o = ctrl_q[CTRL_IRQ_EN_BIT];
    assign high_o   = high_q;
    assign low_o    = low_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/thermal_governor.sv
// Closed-loop heater controller: periodically reads the HeatSensor count and
// switches the heater with hysteresis between the LOW and HIGH thresholds.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | loop disabled, no bus traffic
//   WAIT    | period down-counter running toward the next sample
//   READ    | one-cycle read strobe to the sensor
//   CAPTURE | waiting out the fixed read latency, then latching the sample
//   DECIDE  | hysteresis compare against HIGH/LOW
//   WRITE   | one-cycle heater command write
module thermal_governor
    import thermal_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int READ_LATENCY  = 1,
    parameter int DATA_W        = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    thermal_avs_if.slave  avs,
    thermal_avm_if.master avm,
    output logic          heater_on,
    output logic          irq
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [1:0]       LAT_LOAD    = 2'(READ_LATENCY - 1);
    localparam logic [DATA_W-1:0] CMD_ON     = HEAT_ON[DATA_W-1:0];
    localparam logic [DATA_W-1:0] CMD_OFF    = HEAT_OFF[DATA_W-1:0];

    state_t            state_q;
    logic [CNT_W-1:0]  period_cnt_q;
    logic [1:0]        lat_cnt_q;
    logic [DATA_W-1:0] last_sample_q;
    logic              rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              heater_q;

    logic              en;
    logic              irq_en;
    logic [DATA_W-1:0] high;
    logic [DATA_W-1:0] low;
    logic              over_high;
    logic              under_low;
    logic              irq_set;

    thermal_regs #(.DATA_W(DATA_W)) u_regs (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs           (avs),
        .heater_on_i   (heater_q),
        .last_sample_i (last_sample_q),
        .irq_set_i     (irq_set),
        .en_o          (en),
        .irq_en_o      (irq_en),
        .high_o        (high),
        .low_o         (low),
        .irq_o         (irq)
    );

    // Unsigned threshold compares; HIGH is checked first so overlapping
    // thresholds resolve to heater off.
    assign over_high = (last_sample_q >= high);
    assign under_low = (last_sample_q <= low);
    assign irq_set   = (state_q == ST_DECIDE) && over_high && irq_en;

    // Controller FSM with registered bus strobes; heater_q moves on the same
    // edge that raises the write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            period_cnt_q  <= '0;
            lat_cnt_q     <= '0;
            last_sample_q <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            heater_q      <= 1'b0;
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q  <= ST_WRITE;
                        wr_q     <= 1'b1;
                        wdata_q  <= CMD_OFF;
                        heater_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!en) begin
                        if (heater_q) begin
                            state_q  <= ST_WRITE;
                            wr_q     <= 1'b1;
                            wdata_q  <= CMD_OFF;
                            heater_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (period_cnt_q == '0) begin
                        state_q <= ST_READ;
                        rd_q    <= 1'b1;
                    end else begin
                        period_cnt_q <= period_cnt_q - 1'b1;
                    end
                end
                ST_READ: begin
                    state_q   <= ST_CAPTURE;
                    lat_cnt_q <= LAT_LOAD;
                end
                ST_CAPTURE: begin
                    if (lat_cnt_q == 2'd0) begin
                        last_sample_q <= avm.avm_m0_readdata;
                        state_q       <= ST_DECIDE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                ST_DECIDE: begin
                    if (!en) begin
                        if (heater_q) begin
                            state_q  <= ST_WRITE;
                            wr_q     <= 1'b1;
                            wdata_q  <= CMD_OFF;
                            heater_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (over_high && heater_q) begin
                        state_q  <= ST_WRITE;
                        wr_q     <= 1'b1;
                        wdata_q  <= CMD_OFF;
                        heater_q <= 1'b0;
                    end else if (!over_high && under_low && !heater_q) begin
                        state_q  <= ST_WRITE;
                        wr_q     <= 1'b1;
                        wdata_q  <= CMD_ON;
                        heater_q <= 1'b1;
                    end else begin
                        state_q      <= ST_WAIT;
                        period_cnt_q <= PERIOD_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (en) begin
                        state_q      <= ST_WAIT;
                        period_cnt_q <= PERIOD_LOAD;
                    end else if (heater_q) begin
                        // Disabled right after switching on: turn it back off.
                        wr_q     <= 1'b1;
                        wdata_q  <= CMD_OFF;
                        heater_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm.avm_m0_read      = rd_q;
    assign avm.avm_m0_write     = wr_q;
    assign avm.avm_m0_writedata = wdata_q;
    assign heater_on            = heater_q;

endmodule

// File: tb/tb_thermal_governor.sv
// Directed bench for thermal_governor with a fixed-latency HeatSensor model.
module tb_thermal_governor;
    import thermal_pkg::*;

    localparam int SP = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic heater_on;
    logic irq;

    thermal_avs_if avs ();
    thermal_avm_if #(.DATA_W(32)) avm ();

    thermal_governor #(
        .SAMPLE_PERIOD (SP),
        .READ_LATENCY  (RL),
        .DATA_W        (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avs       (avs),
        .avm       (avm),
        .heater_on (heater_on),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // HeatSensor model: data valid RL cycles after the read strobe, junk otherwise.
    logic [31:0]   sensor_val = 32'd0;
    logic [RL-1:0] rd_pipe;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pipe <= '0;
        else          rd_pipe <= {rd_pipe[RL-2:0], avm.avm_m0_read};
    end
    assign avm.avm_m0_readdata = rd_pipe[RL-1] ? sensor_val : 32'hDEAD_BEEF;

    // Bus activity monitor.
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
    logic [31:0] wr_data = 32'd0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (avm.avm_m0_read) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc = cyc;
        end
        if (avm.avm_m0_write) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            wr_data = avm.avm_m0_writedata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic wait_cycle();
        @(negedge clk);
        #1;
        if (avm.avm_m0_read || avm.avm_m0_write) begin
            checks++;
            if (avm.avm_m0_read && avm.avm_m0_write) begin
                errors++;
                $display("FAIL strobe_overlap: read and write both 1 at cycle %0d, required not both", cyc);
            end
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        avs.avs_s0_address   = a;
        avs.avs_s0_writedata = d;
        avs.avs_s0_write     = 1'b1;
        wait_cycle();
        avs.avs_s0_write     = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        avs.avs_s0_address = a;
        avs.avs_s0_read    = 1'b1;
        wait_cycle();
        avs.avs_s0_read    = 1'b0;
        d = avs.avs_s0_readdata;
    endtask

    task automatic wait_write(input int bound, input string name);
        int start = wr_cnt;
        int n = 0;
        while (wr_cnt == start && n < bound) begin
            wait_cycle();
            n++;
        end
        checks++;
        if (wr_cnt == start) begin
            errors++;
            $display("FAIL %s: no heater write within %0d cycles, required one", name, bound);
        end
    endtask

    task automatic wait_read(input int bound, input string name);
        int start = rd_cnt;
        int n = 0;
        while (rd_cnt == start && n < bound) begin
            wait_cycle();
            n++;
        end
        checks++;
        if (rd_cnt == start) begin
            errors++;
            $display("FAIL %s: no sensor read within %0d cycles, required one", name, bound);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        avs.avs_s0_address = 2'd0; avs.avs_s0_read = 1'b0;
        avs.avs_s0_write = 1'b0;   avs.avs_s0_writedata = 32'd0;
        reset_n = 1'b0;
        #15;
        checks++;
        if ({heater_on, irq, avm.avm_m0_read, avm.avm_m0_write, avm.avm_m0_writedata, avs.avs_s0_readdata} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got h=%b i=%b r=%b w=%b wd=%h rd=%h, required all 0",
                     heater_on, irq, avm.avm_m0_read, avm.avm_m0_write, avm.avm_m0_writedata, avs.avs_s0_readdata);
        end
        #5 reset_n = 1'b1;
        wait_cycle();
        reg_read(REG_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status: got %h, required 00000000", d); end
        reg_read(REG_HIGH, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_high: got %h, required ffffffff", d); end
        repeat (2000) wait_cycle();
        checks++;
        if (rd_cnt !== 0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL idle_quiet: got reads=%0d writes=%0d, required 0 and 0", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_enable();
        logic [31:0] d;
        int r0, first_wr;
        sensor_val = 32'd100;
        reg_write(REG_HIGH, 32'd800);
        reg_write(REG_LOW, 32'd200);
        reg_write(REG_CTRL, 32'd1);
        wait_write(10, "enable_off_write");
        checks++;
        if (wr_data !== 32'd0 || heater_on !== 1'b0) begin
            errors++; $display("FAIL enable_off_write: got data=%0d heater=%b, required 0 and 0", wr_data, heater_on);
        end
        first_wr = wr_cyc;
        r0 = rd_cnt;
        wait_write(60, "enable_on_write");
        checks++;
        if (wr_data !== 32'd1 || heater_on !== 1'b1) begin
            errors++; $display("FAIL enable_on_write: got data=%0d heater=%b, required 1 and 1", wr_data, heater_on);
        end
        checks++;
        if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL enable_read_count: got %0d, required 1", rd_cnt - r0); end
        checks++;
        if (rd_cyc - first_wr !== SP + 1) begin
            errors++; $display("FAIL period_spacing: got %0d cycles, required %0d", rd_cyc - first_wr, SP + 1);
        end
        checks++;
        if (wr_cyc - rd_cyc !== RL + 2) begin
            errors++; $display("FAIL read_to_write: got %0d cycles, required %0d", wr_cyc - rd_cyc, RL + 2);
        end
        reg_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h8000_0064) begin errors++; $display("FAIL enable_status: got %h, required 80000064", d); end
    endtask

    task automatic test_hysteresis();
        logic [31:0] d;
        int w0;
        sensor_val = 32'd500;
        w0 = wr_cnt;
        wait_read(40, "hyst_read_500");
        repeat (RL + 4) wait_cycle();
        checks++;
        if (wr_cnt !== w0 || heater_on !== 1'b1) begin
            errors++; $display("FAIL hyst_500_hold: got writes=%0d heater=%b, required 0 and 1", wr_cnt - w0, heater_on);
        end
        reg_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h8000_01F4) begin errors++; $display("FAIL hyst_status_500: got %h, required 800001f4", d); end
        sensor_val = 32'd900;
        wait_write(40, "hyst_off_write");
        checks++;
        if (wr_data !== 32'd0 || heater_on !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL hyst_900_off: got data=%0d heater=%b irq=%b, required 0 0 0", wr_data, heater_on, irq);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int w0;
        reg_write(REG_CTRL, 32'd3);
        w0 = wr_cnt;
        wait_read(40, "irq_read");
        repeat (4) wait_cycle();
        checks++;
        if (irq !== 1'b1 || wr_cnt !== w0) begin
            errors++; $display("FAIL irq_set: got irq=%b writes=%0d, required 1 and 0", irq, wr_cnt - w0);
        end
        repeat (5) wait_cycle();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b, required 1", irq); end
        reg_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h4000_0384) begin errors++; $display("FAIL irq_status: got %h, required 40000384", d); end
        reg_write(REG_STATUS, 32'h4000_0000);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
        wait_read(40, "irq_race_read");
        repeat (3) wait_cycle();
        reg_write(REG_STATUS, 32'h4000_0000);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_beats_clear: got %b, required 1", irq); end
    endtask

    task automatic test_disable_mid_read();
        logic [31:0] d;
        int r0, w0;
        reg_write(REG_CTRL, 32'd1);
        reg_write(REG_STATUS, 32'h4000_0000);
        sensor_val = 32'd150;
        wait_write(40, "dis_on_write");
        checks++;
        if (wr_data !== 32'd1 || heater_on !== 1'b1) begin
            errors++; $display("FAIL dis_on_write: got data=%0d heater=%b, required 1 and 1", wr_data, heater_on);
        end
        sensor_val = 32'd170;
        wait_read(40, "dis_read");
        wait_cycle();
        reg_write(REG_CTRL, 32'd0);
        r0 = rd_cnt;
        wait_write(10, "dis_off_write");
        checks++;
        if (wr_data !== 32'd0 || heater_on !== 1'b0) begin
            errors++; $display("FAIL dis_off_write: got data=%0d heater=%b, required 0 and 0", wr_data, heater_on);
        end
        reg_read(REG_STATUS, d);
        checks++;
        if (d !== 32'd170) begin errors++; $display("FAIL dis_last_sample: got %h, required 000000aa", d); end
        w0 = wr_cnt;
        repeat (100) wait_cycle();
        checks++;
        if (rd_cnt !== r0 || wr_cnt !== w0) begin
            errors++; $display("FAIL dis_idle: got reads=%0d writes=%0d, required 0 and 0", rd_cnt - r0, wr_cnt - w0);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int r0, w0;
        sensor_val = 32'd100;
        reg_write(REG_CTRL, 32'd1);
        wait_write(10, "ar_off_write");
        wait_write(40, "ar_on_write");
        checks++;
        if (heater_on !== 1'b1) begin errors++; $display("FAIL ar_heater_on: got %b, required 1", heater_on); end
        repeat (3) wait_cycle();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({heater_on, irq, avm.avm_m0_read, avm.avm_m0_write, avm.avm_m0_writedata, avs.avs_s0_readdata} !== 67'd0) begin
            errors++;
            $display("FAIL async_reset: got h=%b i=%b r=%b w=%b wd=%h rd=%h, required all 0",
                     heater_on, irq, avm.avm_m0_read, avm.avm_m0_write, avm.avm_m0_writedata, avs.avs_s0_readdata);
        end
        #1 reset_n = 1'b1;
        wait_cycle();
        reg_read(REG_CTRL, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ar_ctrl: got %h, required 00000000", d); end
        r0 = rd_cnt;
        w0 = wr_cnt;
        repeat (50) wait_cycle();
        checks++;
        if (rd_cnt !== r0 || wr_cnt !== w0) begin
            errors++; $display("FAIL ar_quiet: got reads=%0d writes=%0d, required 0 and 0", rd_cnt - r0, wr_cnt - w0);
        end
        reg_write(REG_HIGH, 32'd800);
        reg_write(REG_LOW, 32'd200);
        reg_write(REG_CTRL, 32'd1);
        wait_write(10, "ar_restart_off");
        checks++;
        if (wr_data !== 32'd0) begin errors++; $display("FAIL ar_restart_off: got %0d, required 0", wr_data); end
        wait_write(40, "ar_restart_on");
        checks++;
        if (wr_data !== 32'd1 || heater_on !== 1'b1) begin
            errors++; $display("FAIL ar_restart_on: got data=%0d heater=%b, required 1 and 1", wr_data, heater_on);
        end
    endtask

    task automatic test_overlap();
        int w0;
        reg_write(REG_HIGH, 32'd100);
        reg_write(REG_LOW, 32'd500);
        sensor_val = 32'd300;
        wait_write(40, "ovl_off_write");
        checks++;
        if (wr_data !== 32'd0 || heater_on !== 1'b0) begin
            errors++; $display("FAIL ovl_off_write: got data=%0d heater=%b, required 0 and 0", wr_data, heater_on);
        end
        w0 = wr_cnt;
        repeat (SP + 8) wait_cycle();
        checks++;
        if (wr_cnt !== w0 || heater_on !== 1'b0) begin
            errors++; $display("FAIL ovl_stays_off: got writes=%0d heater=%b, required 0 and 0", wr_cnt - w0, heater_on);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_hysteresis();
        test_irq();
        test_disable_mid_read();
        test_async_reset();
        test_overlap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
